nanov_uart_tx_sched: RTL

- Store-bus peripheral that decodes CPU stores aimed at the UART and buffers the transmit bytes in a FIFO.
- Sequences the shared uart_tx serialiser: one byte is launched at a time, and the next byte waits until the serialiser's busy flag drops.
- Sits between nanoV_cpu's store outputs (data_out, store_addr_out, store_data_out) and the uart_tx instance in the top level.
- Replaces the direct is_data→uart_tx_en path, which silently loses bytes stored while the serialiser is busy.

---
 rtl/nanov_uart_tx_sched.sv | 105 ++++++++++
 1 files changed

// File: rtl/nanov_uart_tx_sched.sv
// Decodes CPU stores to the UART registers, queues TX bytes in a FIFO and
// launches them one at a time into the shared uart_tx serialiser.
module nanov_uart_tx_sched #(
  parameter int          DEPTH     = 8,
  parameter int          AW        = 3,
  parameter logic [31:0] TX_ADDR   = 32'h1000_0100,
  parameter logic [31:0] CTRL_ADDR = 32'h1000_0104
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   data_in,
  input  logic          store_addr,
  input  logic          store_data,
  input  logic          uart_busy,
  output logic          uart_en,
  output logic [7:0]    uart_data,
  output logic [AW:0]   fifo_level,
  output logic          fifo_full,
  output logic          overflow
);

  typedef enum logic [1:0] {IDLE, START, GUARD, DRAIN} state_t;

  state_t        state, state_nxt;
  logic          sel_tx, sel_ctrl;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    byte_in;
  logic          push, clr, pop, accept, drop, load_head, has_data;

  // CPU bus is bit-serial ordered: byte bit i sits at data_in[31-i].
  always_comb begin
    byte_in = '0;
    for (int i = 0; i < 8; i++) byte_in[i] = data_in[31-i];
  end

  assign push      = store_data & sel_tx;
  assign clr       = store_data & sel_ctrl;
  assign pop       = (state == START);
  assign fifo_full = (fifo_level == (AW+1)'(DEPTH));
  assign accept    = push & (~fifo_full | pop);
  assign drop      = push & ~accept;
  assign has_data  = (fifo_level != '0);
  assign uart_en   = (state == START);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_tx   <= 1'b0;
      sel_ctrl <= 1'b0;
    end else if (store_addr) begin
      sel_tx   <= (data_in == TX_ADDR);
      sel_ctrl <= (data_in == CTRL_ADDR);
    end
  end

  // Storage needs no reset: level/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= byte_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
      // A dropped push wins over a coincident clear.
      if (drop)     overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    load_head = 1'b0;
    case (state)
      IDLE:  if (has_data) state_nxt = START;
      START: state_nxt = GUARD;
      GUARD: state_nxt = DRAIN;
      DRAIN: if (!uart_busy) state_nxt = has_data ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == START && state != START) load_head = 1'b1;
  end

  // Head byte is captured on entry to START so it is stable while uart_en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      uart_data <= '0;
    end else begin
      state <= state_nxt;
      if (load_head) uart_data <= mem[rd_ptr];
    end
  end

endmodule
